// File: rtl/float_div_core.sv
// Iterative radix-2 restoring divider for IEEE-754 binary32 (a / b).
// Special operands resolve to a packed result; everything else yields an unrounded quotient.
module float_div_core #(
    parameter int ITER = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        start,
    input  logic [2:0]  rm_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        valid,
    output logic [2:0]  rm,
    output logic [23:0] man,
    output logic [9:0]  Exp,
    output logic        sgn,
    output logic        round_bit,
    output logic        sticky_bit,
    output logic        IV,
    output logic        DZ,
    output logic        final_res
);

    typedef enum logic [1:0] {IDLE, PREP, DIV, OUT} state_t;

    state_t              state_reg, state_next;
    logic [31:0]         a_reg, b_reg;
    logic [2:0]          rm_reg;
    logic [23:0]         mb_reg;
    logic [25:0]         rem_reg;
    logic [ITER-1:0]     q_reg;
    logic [4:0]          cnt_reg;
    logic signed [9:0]   e_reg;
    logic                fin_reg, iv_reg, dz_reg, sgn_reg;
    logic [23:0]         fman_reg;
    logic [7:0]          fexp_reg;

    function automatic logic [4:0] clz24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    logic [31:0]       op [2];
    logic [1:0]        is_zero, is_inf, is_nan, is_snan;
    logic [23:0]       m_norm [2];
    logic signed [9:0] e_norm [2];

    assign op[0] = a_reg;
    assign op[1] = b_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            logic [7:0]  bexp;
            logic [22:0] frac;
            logic [23:0] mant;
            logic [4:0]  lz;
            assign bexp = op[gi][30:23];
            assign frac = op[gi][22:0];
            assign mant = {(bexp != 8'd0), frac};
            assign lz   = clz24(mant);
            assign is_zero[gi] = (bexp == 8'd0) && (frac == 23'd0);
            assign is_inf[gi]  = (bexp == 8'hFF) && (frac == 23'd0);
            assign is_nan[gi]  = (bexp == 8'hFF) && (frac != 23'd0);
            assign is_snan[gi] = is_nan[gi] && !frac[22];
            // Denormals are shifted up so the hidden bit is always set
            assign m_norm[gi] = mant << lz;
            assign e_norm[gi] = $signed({2'b00, (bexp == 8'd0) ? 8'd1 : bexp})
                              - 10'sd127 - $signed({5'b00000, lz});
        end
    endgenerate

    logic              special, sp_iv, sp_dz, sp_sgn;
    logic [7:0]        sp_exp;
    logic [23:0]       sp_man;
    logic signed [9:0] e_diff;
    logic              ma_lt;
    logic              q_bit;
    logic [25:0]       rem_after, rem_shift;

    always_comb begin
        special = 1'b1;
        sp_iv   = 1'b0;
        sp_dz   = 1'b0;
        sp_sgn  = a_reg[31] ^ b_reg[31];
        sp_exp  = 8'hFF;
        sp_man  = 24'd0;
        if (|is_nan) begin
            sp_iv  = |is_snan;
            sp_sgn = 1'b0;
            sp_man = 24'h400000;
        end else if ((&is_inf) || (&is_zero)) begin
            sp_iv  = 1'b1;
            sp_sgn = 1'b0;
            sp_man = 24'h400000;
        end else if (is_inf[0]) begin
            sp_exp = 8'hFF;
        end else if (is_zero[1]) begin
            sp_dz  = 1'b1;
        end else if (is_inf[1] || is_zero[0]) begin
            sp_exp = 8'h00;
        end else begin
            special = 1'b0;
        end
    end

    assign e_diff    = e_norm[0] - e_norm[1];
    assign ma_lt     = m_norm[0] < m_norm[1];
    assign q_bit     = rem_reg >= {2'b00, mb_reg};
    assign rem_after = q_bit ? (rem_reg - {2'b00, mb_reg}) : rem_reg;
    assign rem_shift = rem_after << 1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start && !valid) state_next = PREP;
            PREP: state_next = special ? OUT : DIV;
            DIV:  if (cnt_reg == 5'd0) state_next = OUT;
            OUT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) state_reg <= IDLE;
        else                 state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            a_reg <= '0; b_reg <= '0; rm_reg <= '0;
            mb_reg <= '0; rem_reg <= '0; q_reg <= '0; cnt_reg <= '0; e_reg <= '0;
            fin_reg <= 1'b0; iv_reg <= 1'b0; dz_reg <= 1'b0; sgn_reg <= 1'b0;
            fman_reg <= '0; fexp_reg <= '0;
            busy <= 1'b0; valid <= 1'b0; rm <= '0; man <= '0; Exp <= '0; sgn <= 1'b0;
            round_bit <= 1'b0; sticky_bit <= 1'b0; IV <= 1'b0; DZ <= 1'b0; final_res <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The valid cycle still belongs to the previous operation
                    if (start && !valid) begin
                        a_reg  <= a;
                        b_reg  <= b;
                        rm_reg <= rm_in;
                        busy   <= 1'b1;
                    end
                end
                PREP: begin
                    fin_reg  <= special;
                    iv_reg   <= sp_iv;
                    dz_reg   <= sp_dz;
                    sgn_reg  <= sp_sgn;
                    fman_reg <= sp_man;
                    fexp_reg <= sp_exp;
                    mb_reg   <= m_norm[1];
                    rem_reg  <= ma_lt ? {1'b0, m_norm[0], 1'b0} : {2'b00, m_norm[0]};
                    e_reg    <= ma_lt ? e_diff - 10'sd1 : e_diff;
                    cnt_reg  <= 5'(ITER - 1);
                    q_reg    <= '0;
                end
                DIV: begin
                    q_reg   <= {q_reg[ITER-2:0], q_bit};
                    rem_reg <= rem_shift;
                    cnt_reg <= cnt_reg - 5'd1;
                end
                OUT: begin
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    rm    <= rm_reg;
                    sgn   <= sgn_reg;
                    if (fin_reg) begin
                        man        <= fman_reg;
                        Exp        <= {2'b00, fexp_reg};
                        round_bit  <= 1'b0;
                        sticky_bit <= 1'b0;
                        IV         <= iv_reg;
                        DZ         <= dz_reg;
                        final_res  <= 1'b1;
                    end else begin
                        man        <= q_reg[24:1];
                        Exp        <= e_reg;
                        round_bit  <= q_reg[0];
                        sticky_bit <= |rem_reg;
                        IV         <= 1'b0;
                        DZ         <= 1'b0;
                        final_res  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_div_core.sv
// Self-checking bench for float_div_core: directed, randomized, abort and start-while-busy scenarios.
module tb_float_div_core;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  rm_in = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, valid, sgn, round_bit, sticky_bit, IV, DZ, final_res;
    logic [2:0]  rm;
    logic [23:0] man;
    logic [9:0]  Exp;

    int checks = 0;
    int errors = 0;

    float_div_core #(.ITER(25)) dut (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .rm_in(rm_in),
        .a(a), .b(b), .busy(busy), .valid(valid), .rm(rm), .man(man), .Exp(Exp),
        .sgn(sgn), .round_bit(round_bit), .sticky_bit(sticky_bit), .IV(IV), .DZ(DZ),
        .final_res(final_res)
    );

    always #5 clk = ~clk;

    // {final_res, IV, DZ, sgn, Exp, man, round_bit, sticky_bit, rm}
    function automatic logic [42:0] out_vec();
        return {final_res, IV, DZ, sgn, Exp, man, round_bit, sticky_bit, rm};
    endfunction

    function automatic void unpack(input logic [31:0] x, output longint m, output int e);
        if (x[30:23] == 8'd0) begin
            m = longint'(x[22:0]);
            e = -126;
            while (m < 64'h800000) begin
                m = m * 2;
                e = e - 1;
            end
        end else begin
            m = longint'(x[22:0]) + 64'h800000;
            e = int'(x[30:23]) - 127;
        end
    endfunction

    // Reference: quotient computed with whole-number division on the significands
    function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] r,
                                    output logic [42:0] v, output int lat);
        logic xn, yn, xs, ys, xi, yi, xz, yz, s;
        logic fin, iv, dz, sg, rb, sb;
        logic [9:0] ex;
        logic [23:0] mn;
        longint mx, my, q, rr;
        int ex_x, ex_y, e;
        xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        xs = xn && !x[22];
        ys = yn && !y[22];
        xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        xz = (x[30:0] == 0);
        yz = (y[30:0] == 0);
        s  = x[31] ^ y[31];
        fin = 1'b1; iv = 1'b0; dz = 1'b0; sg = s; rb = 1'b0; sb = 1'b0;
        ex = 10'h0FF; mn = 24'd0;
        lat = 2;
        if (xn || yn) begin
            iv = xs || ys; sg = 1'b0; mn = 24'h400000;
        end else if ((xi && yi) || (xz && yz)) begin
            iv = 1'b1; sg = 1'b0; mn = 24'h400000;
        end else if (xi) begin
            ex = 10'h0FF;
        end else if (yz) begin
            dz = 1'b1;
        end else if (yi || xz) begin
            ex = 10'h000;
        end else begin
            fin = 1'b0;
            lat = 27;
            unpack(x, mx, ex_x);
            unpack(y, my, ex_y);
            e = ex_x - ex_y;
            if (mx >= my) begin
                q  = (mx <<< 24) / my;
                rr = (mx <<< 24) % my;
            end else begin
                q  = (mx <<< 25) / my;
                rr = (mx <<< 25) % my;
                e  = e - 1;
            end
            mn = 24'(q >>> 1);
            rb = q[0];
            sb = (rr != 0);
            ex = 10'(e);
        end
        v = {fin, iv, dz, sg, ex, mn, rb, sb, r};
    endfunction

    function automatic logic [31:0] rand_op();
        int c;
        logic s;
        logic [22:0] f;
        c = $urandom_range(0, 11);
        s = 1'($urandom);
        f = 23'($urandom);
        case (c)
            0: return {s, 31'd0};
            1: return {s, 8'd0, (f == 0) ? 23'd1 : f};
            2: return {s, 8'hFF, 23'd0};
            3: return {s, 8'hFF, (f == 0) ? 23'd1 : f};
            default: return {s, 8'($urandom_range(1, 254)), f};
        endcase
    endfunction

    // Starts a division and waits (bounded) for valid; ends in the valid cycle.
    task automatic run_div(input logic [31:0] x, input logic [31:0] y, input logic [2:0] r,
                           input string name);
        logic [42:0] expv;
        int lat, cyc;
        if (valid === 1'b1) begin
            @(posedge clk); #1;
        end
        ref_div(x, y, r, expv, lat);
        a = x; b = y; rm_in = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, cyc, lat);
        end
        checks++;
        if (out_vec() !== expv) begin
            errors++;
            $display("FAIL %s result a=%h b=%h: got fin/iv/dz/sgn=%b exp=%h man=%h r/s=%b rm=%0d, expected fin/iv/dz/sgn=%b exp=%h man=%h r/s=%b rm=%0d",
                     name, x, y, out_vec()[42:39], out_vec()[38:29], out_vec()[28:5],
                     out_vec()[4:3], out_vec()[2:0], expv[42:39], expv[38:29], expv[28:5],
                     expv[4:3], expv[2:0]);
        end else begin
            $display("%s a=%h b=%h lat=%0d fin=%b iv=%b dz=%b sgn=%b exp=%h man=%h r=%b s=%b",
                     name, x, y, cyc, final_res, IV, DZ, sgn, Exp, man, round_bit, sticky_bit);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, valid, out_vec()} !== 45'd0) begin
            errors++;
            $display("FAIL reset outputs: got %h, expected 0", {busy, valid, out_vec()});
        end
        reset = 1'b1;
        @(posedge clk); #1;
        $display("reset released");
    endtask

    task automatic test_directed();
        run_div(32'h40C00000, 32'h40000000, 3'd0, "six_by_two");
        checks++;
        if ({man, Exp} !== {24'hC00000, 10'd1}) begin
            errors++;
            $display("FAIL six_by_two const: got man=%h exp=%h, expected man=c00000 exp=001", man, Exp);
        end
        run_div(32'h3F800000, 32'h40400000, 3'd1, "one_by_three");
        checks++;
        if ({man, Exp, round_bit, sticky_bit} !== {24'hAAAAAA, 10'h3FE, 2'b11}) begin
            errors++;
            $display("FAIL one_by_three const: got man=%h exp=%h r=%b s=%b, expected aaaaaa 3fe 1 1",
                     man, Exp, round_bit, sticky_bit);
        end
        run_div(32'h3F800000, 32'h00000000, 3'd2, "one_by_zero");
        run_div(32'h00000000, 32'h00000000, 3'd3, "zero_by_zero");
        run_div(32'h7F800001, 32'h3F800000, 3'd4, "snan");
        run_div(32'h00000001, 32'h3F800000, 3'd0, "denorm");
        checks++;
        if ({man, Exp} !== {24'h800000, 10'h36B}) begin
            errors++;
            $display("FAIL denorm const: got man=%h exp=%h, expected man=800000 exp=36b", man, Exp);
        end
        run_div(32'hFF800000, 32'h40000000, 3'd1, "neg_inf_by_two");
        run_div(32'h3F800000, 32'hFF800000, 3'd1, "one_by_neg_inf");
        run_div(32'h7F7FFFFF, 32'h00000001, 3'd0, "max_by_min");
        run_div(32'h00000001, 32'h7F7FFFFF, 3'd0, "min_by_max");
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            run_div(rand_op(), rand_op(), 3'($urandom), "random");
        end
    endtask

    task automatic test_abort(input logic use_clear);
        int vcount;
        if (valid === 1'b1) begin
            @(posedge clk); #1;
        end
        a = 32'h40490FDB; b = 32'h3F9E0652; rm_in = 3'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        if (use_clear) clear = 1'b1;
        else           reset = 1'b0;
        @(posedge clk); #1;
        clear = 1'b0;
        reset = 1'b1;
        checks++;
        if ({busy, valid, out_vec()} !== 45'd0) begin
            errors++;
            $display("FAIL abort(clear=%0d) outputs: got %h, expected 0", use_clear, {busy, valid, out_vec()});
        end
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) vcount++;
        end
        checks++;
        if (vcount !== 0) begin
            errors++;
            $display("FAIL abort(clear=%0d) valid count: got %0d, expected 0", use_clear, vcount);
        end
        $display("abort clear=%0d done", use_clear);
        run_div(32'h40C00000, 32'h40000000, 3'd0, "after_abort");
    endtask

    task automatic test_busy_start();
        logic [42:0] expv;
        int lat, cyc;
        if (valid === 1'b1) begin
            @(posedge clk); #1;
        end
        ref_div(32'h41200000, 32'h40E00000, 3'd6, expv, lat);
        a = 32'h41200000; b = 32'h40E00000; rm_in = 3'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid: got busy=%b, expected 1", busy);
        end
        a = 32'h3F800000; b = 32'h40400000; rm_in = 3'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 5;
        while (valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc !== lat) begin
            errors++;
            $display("FAIL busy_start latency: got %0d, expected %0d", cyc, lat);
        end
        checks++;
        if (out_vec() !== expv) begin
            errors++;
            $display("FAIL busy_start result: got %h, expected %h", out_vec(), expv);
        end
        $display("busy_start lat=%0d exp=%h man=%h", cyc, Exp, man);
    endtask

    task automatic test_back_to_back();
        int vcount;
        run_div(32'h40400000, 32'h3F800000, 3'd2, "b2b_first");
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, valid} !== 2'b00) begin
            errors++;
            $display("FAIL b2b start in valid cycle: got busy/valid=%b, expected 00", {busy, valid});
        end
        vcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) vcount++;
        end
        checks++;
        if (vcount !== 0) begin
            errors++;
            $display("FAIL b2b ignored start produced valid: got %0d, expected 0", vcount);
        end
        $display("b2b ignored start done");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_abort(1'b0);
        test_abort(1'b1);
        test_busy_start();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
